// File: rtl/mantissa_aligner.sv
// Right-shift aligner: mantissa >> shift with guard/round/sticky, at most STEP bits per cycle.
// Latency: ceil(shift/STEP) SHIFT cycles, then DONE (zero SHIFT cycles for shift 0 or >= MANT_W+2).
// Backpressure: result held in DONE until out_ready; ALIGNER_SKID_EN allows reload on the completing edge.
module mantissa_aligner #(
    parameter int MANT_W  = 24,
    parameter int SHIFT_W = 8,
    parameter int STEP    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MANT_W-1:0]  in_mant,
    input  logic [SHIFT_W-1:0] in_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MANT_W-1:0]  out_mant,
    output logic               out_guard,
    output logic               out_round,
    output logic               out_sticky,
    output logic               busy
);
    localparam int WW = MANT_W + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         state;
    logic [WW-1:0]      w;
    logic               s;
    logic [SHIFT_W-1:0] r;

    logic [SHIFT_W-1:0] d;
    logic [WW-1:0]      lost;

    logic [1:0]         ld_state;
    logic [WW-1:0]      ld_w;
    logic               ld_s;
    logic [SHIFT_W-1:0] ld_r;

    // d never exceeds r, so the remaining count cannot underflow
    assign d    = (r < SHIFT_W'(STEP)) ? r : SHIFT_W'(STEP);
    assign lost = w & ~({WW{1'b1}} << d);

    always_comb begin
        ld_state = SHIFT;
        ld_w     = {in_mant, 2'b00};
        ld_s     = 1'b0;
        ld_r     = in_shift;
        if (in_shift == '0) begin
            ld_state = DONE;
        end else if (int'(in_shift) >= WW) begin
            ld_state = DONE;
            ld_w     = '0;
            ld_s     = |in_mant;
            ld_r     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            w     <= '0;
            s     <= 1'b0;
            r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= ld_state;
                        w     <= ld_w;
                        s     <= ld_s;
                        r     <= ld_r;
                    end
                end
                SHIFT: begin
                    w <= w >> d;
                    s <= s | (|lost);
                    r <= r - d;
                    if (r == d)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
`ifdef ALIGNER_SKID_EN
                        if (in_valid) begin
                            state <= ld_state;
                            w     <= ld_w;
                            s     <= ld_s;
                            r     <= ld_r;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALIGNER_SKID_EN
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
    assign in_ready = (state == IDLE);
`endif

    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_mant   = w[WW-1:2];
    assign out_guard  = w[1];
    assign out_round  = w[0];
    assign out_sticky = s;

endmodule

// File: doc/mantissa_aligner.md
Name: mantissa_aligner

Overview:
- Multi-cycle right-shift aligner for the floating-point coprocessor adder path.
- Performs the inverse of leading-one normalisation: takes a 24-bit mantissa and an exponent difference, and shifts the mantissa right by that amount.
- Produces the aligned mantissa plus guard, round and sticky bits for the rounding stage.
- Uses a valid/ready handshake on both sides. Shifts at most STEP bits per cycle to keep the barrel shifter small.

Parameters:
- MANT_W, 24, mantissa width including hidden bit
- SHIFT_W, 8, width of shift-amount input (exponent difference)
- STEP, 4, maximum bits shifted per cycle; power of two, 1..16

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  aligner can accept an operand
- in_mant  in  MANT_W  mantissa to align
- in_shift  in  SHIFT_W  unsigned right-shift amount
- out_valid  out  1  aligned result valid
- out_ready  in  1  consumer accepts result
- out_mant  out  MANT_W  aligned mantissa
- out_guard  out  1  first bit shifted out below LSB
- out_round  out  1  second bit shifted out
- out_sticky  out  1  OR of all bits shifted out beyond round
- busy  out  1  high in SHIFT or DONE

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i. rst_i dominates all other inputs.
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_mant, out_guard, out_round, out_sticky = 0; busy=0.
- Working register W is MANT_W+2 bits: {mant, guard, round}. Separate sticky flop S. Counter R holds the remaining shift.
- IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready at edge k: W={in_mant,2'b00}, S=0.
  - in_shift==0 -> DONE.
  - in_shift >= MANT_W+2 (26) -> W=0, S=|in_mant, go to DONE.
  - Otherwise R=in_shift, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge: d=min(R,STEP); W=W>>d; S |= OR of the d bits leaving W[0]; R-=d.
  - If the new R==0, go to DONE on the same edge.
  - For 0<s<26, n=ceil(s/STEP). out_valid is first high in the cycle after edge k+n. For s=0 or s>=26, n=0.
- DONE:
  - out_valid=1.
  - Outputs driven from registers: out_mant=W[MANT_W+1:2], out_guard=W[1], out_round=W[0], out_sticky=S.
  - Outputs are held stable while out_ready=0.
  - out_valid & out_ready -> IDLE (unless the optional feature applies).
- in_valid while not in_ready: ignored, no state change; the operand is not captured.
- out_ready while out_valid=0: ignored.
- Reset mid-SHIFT or mid-DONE: operation discarded; no out_valid pulse after reset.
- The shift value is treated as unsigned; no wrap-around of R. R saturates at 0 and never underflows.
- Behaviour is independent of in_mant normalisation (in_mant=0 yields all zeros, sticky=0).

Optional Feature:
- Macro ALIGNER_SKID_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - When both handshakes fire on the same edge, the new operand is loaded exactly as in IDLE. The next state is DONE or SHIFT per the load rules, never IDLE.
  - Gives back-to-back throughput of one result per n+1 cycles.
- Undefined: in_ready=1 only in IDLE, and at least one IDLE cycle separates consecutive results.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, all outputs 0. Assert rst_i during SHIFT -> IDLE next cycle, no out_valid.
- in_mant=0x800000, in_shift=0 -> out_valid one cycle after accept; out_mant=0x800000, guard=round=sticky=0.
- in_mant=0xC00003, in_shift=3, STEP=4 -> out_valid after 1 SHIFT cycle; out_mant=0x180000, guard=0, round=1, sticky=1.
- in_mant=0xFFFFFF, in_shift=10, STEP=4 -> 3 SHIFT cycles (4,4,2); out_mant=0x003FFF, guard=1, round=1, sticky=1.
- in_mant=0x000001, in_shift=40 -> out_valid one cycle after accept; out_mant=0, guard=0, round=0, sticky=1. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- With ALIGNER_SKID_EN: two operands (0x800000,s=4), (0x800000,s=8); out_ready tied 1 -> second accepted on the same edge the first completes, results 0x080000 then 0x008000, no IDLE cycle between. Without the macro -> one IDLE cycle between results.
